// File: rtl/add4_seq_arb_if.sv
// Request, response and external 4-bit adder signals shared by add4_seq_arb and its environment.
interface add4_seq_arb_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ci;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ci;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_co;
    logic             rsp_id;

    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_ci;
    logic [3:0]       add_sum;
    logic             add_co;

    // The sequencer is the slave: it serves requests and owns the adder inputs.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ci,
        input  req1_valid, req1_a, req1_b, req1_ci,
        input  rsp_ready, add_sum, add_co,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_co, rsp_id,
        output add_a, add_b, add_ci
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ci,
        output req1_valid, req1_a, req1_b, req1_ci,
        output rsp_ready, add_sum, add_co,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_co, rsp_id,
        input  add_a, add_b, add_ci
    );
endinterface

// File: rtl/add4_seq_arb.sv
// Round-robin arbiter plus nibble-serial sequencer: each WIDTH-bit add is run as
// WIDTH/4 passes through one external combinational 4-bit adder, chaining carry.
module add4_seq_arb #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    add4_seq_arb_if.slave bus
);

    localparam int NIB   = WIDTH / 4;
    localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [NIB_W-1:0] nib;
    logic             carry_reg;
    logic             last_grant;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_ci;
    logic             op_id;

    logic             rdy0;
    logic             rdy1;
    logic             last_nib;

    // Winner among the valid requesters; on a tie the one not served last wins.
    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

    function automatic logic [3:0] nib_of(input logic [WIDTH-1:0] v,
                                          input logic [NIB_W-1:0] idx);
        logic [WIDTH-1:0] s;
        s = v >> {idx, 2'b00};
        return s[3:0];
    endfunction

    function automatic logic [WIDTH-1:0] put_nib(input logic [WIDTH-1:0] v,
                                                 input logic [NIB_W-1:0] idx,
                                                 input logic [3:0]       n);
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] ins;
        mask = WIDTH'(4'hF) << {idx, 2'b00};
        ins  = WIDTH'(n) << {idx, 2'b00};
        return (v & ~mask) | ins;
    endfunction

    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (state == IDLE) begin
            if (pick(bus.req0_valid, bus.req1_valid, last_grant)) begin
                rdy1 = bus.req1_valid;
            end else begin
                rdy0 = bus.req0_valid;
            end
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign last_nib       = (nib == NIB_W'(NIB - 1));

    // Adder port is only driven while a pass is in flight.
    always_comb begin
        bus.add_a  = 4'h0;
        bus.add_b  = 4'h0;
        bus.add_ci = 1'b0;
        if (state == RUN) begin
            bus.add_a  = nib_of(op_a, nib);
            bus.add_b  = nib_of(op_b, nib);
            bus.add_ci = (nib == '0) ? op_ci : carry_reg;
        end
    end

    // Operand capture at accept; these registers need no reset.
    always_ff @(posedge clk) begin
        if (rdy0 || rdy1) begin
            op_a  <= rdy1 ? bus.req1_a  : bus.req0_a;
            op_b  <= rdy1 ? bus.req1_b  : bus.req0_b;
            op_ci <= rdy1 ? bus.req1_ci : bus.req0_ci;
            op_id <= rdy1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            nib           <= '0;
            carry_reg     <= 1'b0;
            last_grant    <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_co    <= 1'b0;
            bus.rsp_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdy0 || rdy1) begin
                        state <= RUN;
                        nib   <= '0;
                    end
                end
                RUN: begin
                    // rsp_sum doubles as the result accumulator; rsp_valid qualifies it.
                    bus.rsp_sum <= put_nib(bus.rsp_sum, nib, bus.add_sum);
                    carry_reg   <= bus.add_co;
                    nib         <= nib + 1'b1;
                    if (last_nib) begin
                        state         <= DONE;
                        nib           <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_co    <= bus.add_co;
                        bus.rsp_id    <= op_id;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        last_grant    <= bus.rsp_id;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add4_seq_arb.sv
// Directed bench for add4_seq_arb with a behavioural 4-bit adder on the add port.
module tb_add4_seq_arb;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    add4_seq_arb_if #(.WIDTH(WIDTH)) bus ();

    add4_seq_arb #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign {bus.add_co, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_ci};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic ci);
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = a;
            bus.req1_b     = b;
            bus.req1_ci    = ci;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = a;
            bus.req0_b     = b;
            bus.req0_ci    = ci;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_sum"},   32'(bus.rsp_sum), 0);
        chk({tag, "_rsp_co"},    32'(bus.rsp_co), 0);
        chk({tag, "_rsp_id"},    32'(bus.rsp_id), 0);
        chk({tag, "_add_a"},     32'(bus.add_a), 0);
        chk({tag, "_add_b"},     32'(bus.add_b), 0);
        chk({tag, "_add_ci"},    32'(bus.add_ci), 0);
    endtask

    // Entry: IDLE, requester id already presenting. Exit: one cycle after the response handshake.
    task automatic run_txn(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp_sum, input logic exp_co,
                           input logic [NIB-1:0] exp_ci, input int stall, input logic drop);
        chk("grant_ready0", 32'(bus.req0_ready), 32'(id == 1'b0));
        chk("grant_ready1", 32'(bus.req1_ready), 32'(id));
        tick();
        if (drop) begin
            if (id) bus.req1_valid = 1'b0;
            else    bus.req0_valid = 1'b0;
        end
        for (int k = 0; k < NIB; k++) begin
            chk("pass_add_a",  32'(bus.add_a), 32'((a >> (4 * k)) & 16'h000F));
            chk("pass_add_b",  32'(bus.add_b), 32'((b >> (4 * k)) & 16'h000F));
            chk("pass_add_ci", 32'(bus.add_ci), 32'(exp_ci[k]));
            chk("busy_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("busy_req_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
            tick();
        end
        for (int s = 0; s <= stall; s++) begin
            chk("done_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("done_rsp_sum",   32'(bus.rsp_sum), 32'(exp_sum));
            chk("done_rsp_co",    32'(bus.rsp_co), 32'(exp_co));
            chk("done_rsp_id",    32'(bus.rsp_id), 32'(id));
            chk("done_req_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
            chk("done_add_a",     32'(bus.add_a), 0);
            if (s < stall) tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("after_hs_rsp_valid", 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_ci    = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_ci    = 1'b0;
        bus.rsp_ready  = 1'b0;
        #12;
        chk_quiet("reset");
        chk("reset_req_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain add, no carries; rsp_valid rises NIB edges after accept.
        set_req(1'b0, 16'h1234, 16'h4321, 1'b0);
        #1;
        run_txn(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 4'b0000, 0, 1'b1);

        // Full-width carry ripple and wrap-around.
        set_req(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        #1;
        run_txn(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4'b1110, 0, 1'b1);

        // Carry-in feeds pass 0, its carry-out feeds pass 1.
        set_req(1'b0, 16'h000F, 16'h0000, 1'b1);
        #1;
        run_txn(1'b0, 16'h000F, 16'h0000, 16'h0010, 1'b0, 4'b0011, 0, 1'b1);

        // last_grant is now 0, so requester 1 wins the tie; abort it at nib=2.
        set_req(1'b0, 16'h0101, 16'h0202, 1'b0);
        set_req(1'b1, 16'h8421, 16'h8000, 1'b1);
        #1;
        chk("tie_ready1", 32'(bus.req1_ready), 1);
        chk("tie_ready0", 32'(bus.req0_ready), 0);
        tick();
        tick();
        tick();
        chk("nib2_add_a", 32'(bus.add_a), 32'h4);
        chk("nib2_add_b", 32'(bus.add_b), 32'h0);
        rst_n = 1'b0;
        #1;
        chk_quiet("abort");
        chk("abort_ready0", 32'(bus.req0_ready), 1);
        chk("abort_ready1", 32'(bus.req1_ready), 0);
        tick();
        chk("abort_hold_rsp_valid", 32'(bus.rsp_valid), 0);
        rst_n = 1'b1;
        #1;

        // Both requesters stay valid: grants alternate 0,1,0,1; first result stalls 5 cycles.
        run_txn(1'b0, 16'h0101, 16'h0202, 16'h0303, 1'b0, 4'b0000, 5, 1'b0);
        run_txn(1'b1, 16'h8421, 16'h8000, 16'h0422, 1'b1, 4'b0001, 0, 1'b0);
        run_txn(1'b0, 16'h0101, 16'h0202, 16'h0303, 1'b0, 4'b0000, 0, 1'b0);
        run_txn(1'b1, 16'h8421, 16'h8000, 16'h0422, 1'b1, 4'b0001, 0, 1'b0);

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("final_req_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
        chk("final_rsp_valid", 32'(bus.rsp_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
